// File: rtl/regwr_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the write-stage state encoding and the hard-wired zero register index.
package regwr_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  // Register 0 is hard-wired; writes to it are granted but never performed
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request always wins, and on contention
// prio selects the winner (0 favours requester 0, 1 favours requester 1).
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = ~prio;
      gnt1 = prio;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/regwr_arbiter.sv
// Arbitrates two register-file write requesters onto one registered write port.
// Optional feature: define REGWR_ARB_FWD_EN to add the write-to-read forwarding port.
module regwr_arbiter
  import regwr_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          ld,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          busy
`ifdef REGWR_ARB_FWD_EN
  ,
  input  logic [AW-1:0] rd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data
`endif
);

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          zero_dst_q, zero_dst_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          pick_gnt0, pick_gnt1;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .prio (prio_q),
    .gnt0 (pick_gnt0),
    .gnt1 (pick_gnt1)
  );

  // Grants are masked by reset so nothing is offered while the block is held
  assign gnt0 = pick_gnt0 & rst;
  assign gnt1 = pick_gnt1 & rst;
  assign busy = (req0 & ~gnt0) | (req1 & ~gnt1);

  always_comb begin
    state_d    = IDLE;
    prio_d     = prio_q;
    zero_dst_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (gnt0) begin
      state_d    = WR0;
      prio_d     = 1'b1;
      zero_dst_d = (addr0 == AW'(ZERO_REG));
      waddr_d    = addr0;
      wdata_d    = data0;
    end else if (gnt1) begin
      state_d    = WR1;
      prio_d     = 1'b0;
      zero_dst_d = (addr1 == AW'(ZERO_REG));
      waddr_d    = addr1;
      wdata_d    = data1;
    end
  end

  always_ff @(posedge ld or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      zero_dst_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      zero_dst_q <= zero_dst_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Write enable follows the state flop, so an async reset kills it at once
  assign rf_we    = (state_q != IDLE) & ~zero_dst_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

`ifdef REGWR_ARB_FWD_EN
  assign fwd_hit  = rf_we & (rd_addr == waddr_q) & (rd_addr != AW'(ZERO_REG));
  assign fwd_data = wdata_q;
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// Randomized self-checking bench for regwr_arbiter against a behavioural model
// of the arbitration rules (last-granted pointer, one-cycle write latency).
module tb_regwr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          ld = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
`ifdef REGWR_ARB_FWD_EN
  logic [AW-1:0] rd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model: who was granted last, and what the write port should show
  int            mLast;
  logic          mWe;
  logic [AW-1:0] mWaddr;
  logic [DW-1:0] mWdata;

  regwr_arbiter #(.DW(DW), .AW(AW)) dut (
    .ld       (ld),
    .rst      (rst),
    .req0     (req0),
    .addr0    (addr0),
    .data0    (data0),
    .gnt0     (gnt0),
    .req1     (req1),
    .addr1    (addr1),
    .data1    (data1),
    .gnt1     (gnt1),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy)
`ifdef REGWR_ARB_FWD_EN
    ,
    .rd_addr  (rd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
`endif
  );

  // Free-running clock on ld, rising edges at 5, 15, 25 ...
  always #5 ld = ~ld;

  // Watchdog so a stuck run still ends with a visible failure
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts every comparison and reports any disagreement with the model
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mLast  = 1;
    mWe    = 1'b0;
    mWaddr = '0;
    mWdata = '0;
  endtask

  task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0  = r0;
    addr0 = a0;
    data0 = d0;
    req1  = r1;
    addr1 = a1;
    data1 = d1;
  endtask

  // One full ld period starting at a falling edge: drive, check grants,
  // advance the model on the rising edge, check the write port, return at
  // the next falling edge. Expected grants are handed back to the caller.
  task automatic runCycle(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          output logic eg0, output logic eg1);
    applyStimulus(r0, a0, d0, r1, a1, d1);
    #1;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (r0 && r1) begin
      if (mLast == 0) eg1 = 1'b1;
      else            eg0 = 1'b1;
    end else begin
      eg0 = r0;
      eg1 = r1;
    end
    checkOutput("gnt0", 64'(gnt0), 64'(eg0));
    checkOutput("gnt1", 64'(gnt1), 64'(eg1));
    checkOutput("busy", 64'(busy), 64'((r0 && !eg0) || (r1 && !eg1)));
    @(posedge ld);
    if (eg0) begin
      mWe = (a0 != 0); mWaddr = a0; mWdata = d0; mLast = 0;
    end else if (eg1) begin
      mWe = (a1 != 0); mWaddr = a1; mWdata = d1; mLast = 1;
    end else begin
      mWe = 1'b0;
    end
    #1;
    checkOutput("rf_we",    64'(rf_we),    64'(mWe));
    checkOutput("rf_waddr", 64'(rf_waddr), 64'(mWaddr));
    checkOutput("rf_wdata", 64'(rf_wdata), 64'(mWdata));
`ifdef REGWR_ARB_FWD_EN
    checkOutput("fwd_hit", 64'(fwd_hit), 64'(mWe && (rd_addr == mWaddr) && (rd_addr != 0)));
    checkOutput("fwd_data", 64'(fwd_data), 64'(mWdata));
`endif
    @(negedge ld);
  endtask

  // Directed scenarios first, then a randomized run with held requests
  initial begin
    logic          g0, g1;
    logic          pend0, pend1;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;

    modelReset();
    rst = 1'b0;
    applyStimulus(1'b1, AW'(9), 32'hA5A5_0009, 1'b0, '0, '0);
    #1;
    checkOutput("rst_gnt0",     64'(gnt0),     64'(0));
    checkOutput("rst_rf_we",    64'(rf_we),    64'(0));
    checkOutput("rst_rf_waddr", 64'(rf_waddr), 64'(0));
    checkOutput("rst_rf_wdata", 64'(rf_wdata), 64'(0));
    checkOutput("rst_busy",     64'(busy),     64'(1));
    @(negedge ld);
    rst = 1'b1;
    runCycle(1'b1, AW'(9), 32'hA5A5_0009, 1'b0, '0, '0, g0, g1);

    // Single request, then idle so rf_we must drop again
    runCycle(1'b1, AW'(5), 32'hDEAD_BEEF, 1'b0, '0, '0, g0, g1);
    runCycle(1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
    runCycle(1'b0, '0, '0, 1'b0, '0, '0, g0, g1);

    // Register 0 target: granted, but no write is performed
    runCycle(1'b0, '0, '0, 1'b1, AW'(0), 32'h0000_1234, g0, g1);
    runCycle(1'b0, '0, '0, 1'b0, '0, '0, g0, g1);

    // Async reset while a write is on the port
    runCycle(1'b1, AW'(12), 32'hCAFE_F00D, 1'b0, '0, '0, g0, g1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    checkOutput("pre_rst_we", 64'(rf_we), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_we",    64'(rf_we),    64'(0));
    checkOutput("mid_rst_waddr", 64'(rf_waddr), 64'(0));
    #1;
    rst = 1'b1;
    @(negedge ld);

    // Contention straight after reset alternates starting with requester 0
    for (int i = 0; i < 4; i++) begin
      runCycle(1'b1, AW'(3), 32'h0000_0300 + i, 1'b1, AW'(4), 32'h0000_0400 + i, g0, g1);
      checkOutput("contend_gnt0", 64'(g0), 64'((i % 2) == 0));
    end
    runCycle(1'b0, '0, '0, 1'b0, '0, '0, g0, g1);

`ifdef REGWR_ARB_FWD_EN
    rd_addr = AW'(7);
    runCycle(1'b1, AW'(7), 32'h0000_0055, 1'b0, '0, '0, g0, g1);
    checkOutput("fwd_hit_7",  64'(fwd_hit),  64'(1));
    checkOutput("fwd_data_7", 64'(fwd_data), 64'(32'h55));
    rd_addr = AW'(0);
    #1;
    checkOutput("fwd_hit_0", 64'(fwd_hit), 64'(0));
    runCycle(1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
`endif

    // Randomized traffic: a request stays asserted with fixed payload until granted
    pend0 = 1'b0; pend1 = 1'b0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend0 && ($urandom_range(0, 2) != 0)) begin
        pend0 = 1'b1;
        pa0   = ($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
        pd0   = $urandom;
      end
      if (!pend1 && ($urandom_range(0, 2) != 0)) begin
        pend1 = 1'b1;
        pa1   = ($urandom_range(0, 5) == 0) ? pa0 : AW'($urandom_range(0, 31));
        pd1   = $urandom;
      end
`ifdef REGWR_ARB_FWD_EN
      rd_addr = ($urandom_range(0, 1) == 0) ? pa0 : AW'($urandom_range(0, 31));
`endif
      runCycle(pend0, pa0, pd0, pend1, pa1, pd1, g0, g1);
      if (g0) pend0 = 1'b0;
      if (g1) pend1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter DW, default 32, width of register-file write data.
REQ-002 Parameter AW, default 5, width of register-file address.
REQ-003 ld  input  1  clock; all state changes on rising edge of ld.
REQ-004 rst  input  1  reset; asynchronous, active-low (rst=0 resets immediately, independent of ld).
REQ-005 req0  input  1  requester 0 write request; held until gnt0.
REQ-006 addr0  input  AW  requester 0 destination register.
REQ-007 data0  input  DW  requester 0 write data.
REQ-008 gnt0  output  1  combinational grant to requester 0; request accepted at next rising ld.
REQ-009 req1, addr1, data1, gnt1: same as REQ-005..008 for requester 1.
REQ-010 rf_we  output  1  registered register-file write enable.
REQ-011 rf_waddr  output  AW  registered write address.
REQ-012 rf_wdata  output  DW  registered write data.
REQ-013 busy  output  1  high when any req is pending and not granted this cycle.

Function
REQ-014 States IDLE, WR0, WR1; state names the requester whose write is on rf_* this cycle.
REQ-015 At most one of gnt0/gnt1 SHALL be high in any cycle; gnt is high only when matching req is high.
REQ-016 Single request: granted in the same cycle; no idle cycle between back-to-back grants.
REQ-017 Both requesting: grant goes to the requester not granted most recently (pointer prio); after reset prio favours requester 0.
REQ-018 prio SHALL update only on an accepted grant, to point at the other requester.
REQ-019 Accepted request: rf_waddr/rf_wdata take the granted addr/data and rf_we=1 for exactly the following cycle; latency 1 cycle.
REQ-020 Accepted request with addr=0: gnt asserted normally, state moves to WR0/WR1, rf_we SHALL remain 0 (register 0 is never written).
REQ-021 No accepted request: state -> IDLE, rf_we=0, rf_waddr/rf_wdata hold previous values.
REQ-022 Both requesters same address: serialized per REQ-017; second write lands one cycle after first, so last-granted wins.
REQ-023 busy = (req0 & ~gnt0) | (req1 & ~gnt1).

Reset
REQ-024 rst=0 SHALL force state IDLE, prio to requester 0, rf_we=0, rf_waddr=0, rf_wdata=0 asynchronously.
REQ-025 rst asserted mid-write SHALL abort it: rf_we drops without waiting for ld; in-flight write is lost, requester must re-request.
REQ-026 gnt0/gnt1 SHALL be 0 while rst=0.

Configuration
REQ-027 Macro REGWR_ARB_FWD_EN defined: adds input rd_addr (AW), outputs fwd_hit (1) and fwd_data (DW); fwd_hit = rf_we & (rd_addr==rf_waddr) & (rd_addr!=0), fwd_data = rf_wdata.
REQ-028 Macro undefined: rd_addr, fwd_hit, fwd_data absent; all other behaviour identical.

Structure
REQ-029 Package regwr_pkg SHALL hold DW/AW defaults, the state enum (IDLE, WR0, WR1) and constant ZERO_REG=0.
REQ-030 Sub-module rr_pick2 SHALL implement the 2-way round-robin choice (inputs req0, req1, prio; outputs gnt0, gnt1); the pointer register stays in regwr_arbiter.

Verification
REQ-031 Reset: rst=0 at time 0, req0=1 -> gnt0=0, rf_we=0, rf_waddr=0; release rst -> gnt0=1 same cycle, rf_we=1 next cycle.
REQ-032 Single: req0=1, addr0=5, data0=0xDEADBEEF for one cycle -> gnt0=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
REQ-033 Contention: req0 and req1 held 4 cycles after reset (addr0=3, addr1=4) -> grants 0,1,0,1; busy=1 each cycle; rf_waddr sequence 3,4,3,4.
REQ-034 Zero register: req1=1, addr1=0, data1=0x1234 -> gnt1=1, state WR1, rf_we stays 0.
REQ-035 Async reset mid-write: rst=0 while rf_we=1 between ld edges -> rf_we=0 before next edge; after release, prio favours requester 0.
REQ-036 With REGWR_ARB_FWD_EN: write addr 7 data 0x55, rd_addr=7 in write cycle -> fwd_hit=1, fwd_data=0x55; rd_addr=0 -> fwd_hit=0.
